// File: rtl/vga_pkg.sv
// Shared types, geometry and timing constants for the framebuffer VGA scanout.
package vga_pkg;

  // Framebuffer geometry
  localparam int FB_W     = 160;
  localparam int FB_H     = 120;
  localparam int FB_AW    = 15;
  localparam int FB_DEPTH = FB_W * FB_H;

  // Replication factor (power of two) and its shift amount
  localparam int SCALE    = 4;
  localparam int SCALE_SH = 2;

  // Default VGA timing, 640x480@60 with a 4:1 pixel-rate divider
  localparam int CLK_DIV_DEF = 4;
  localparam int H_VIS_DEF   = 640;
  localparam int H_FP_DEF    = 16;
  localparam int H_SYNC_DEF  = 96;
  localparam int H_BP_DEF    = 48;
  localparam int V_VIS_DEF   = 480;
  localparam int V_FP_DEF    = 10;
  localparam int V_SYNC_DEF  = 2;
  localparam int V_BP_DEF    = 33;

  typedef logic [11:0] color_t;
  typedef logic [7:0]  xy_t;

  localparam xy_t FB_W_XY = 8'd160;
  localparam xy_t FB_H_XY = 8'd120;

  // Linear address y*160 + x built from shifts (160 = 128 + 32)
  function automatic logic [FB_AW-1:0] fb_addr(input xy_t x, input xy_t y);
    return {y, 7'b0000000} + {2'b00, y, 5'b00000} + {7'b0000000, x};
  endfunction

endpackage

// File: rtl/fb_ram.sv
// Simple dual-port framebuffer RAM: one write port, one registered read port.
// Contents are not reset; a read of an address written in the same cycle
// returns the previous contents.
module fb_ram
  import vga_pkg::*;
(
  input  logic             clk,
  input  logic             we,
  input  logic [FB_AW-1:0] waddr,
  input  color_t           wdata,
  input  logic             re,
  input  logic [FB_AW-1:0] raddr,
  output color_t           rdata
);

  color_t mem [FB_DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Registered read port, holds its data while re is low
  always_ff @(posedge clk) begin
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/fb_vga_scanout.sv
// Framebuffer writer plus VGA scanout: pixel-rate divider, h/v counters,
// replicated read address generation and a two-stage pipe that keeps sync,
// blanking and RAM data aligned at the outputs.
module fb_vga_scanout
  import vga_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEF,
  parameter int H_VIS   = H_VIS_DEF,
  parameter int H_FP    = H_FP_DEF,
  parameter int H_SYNC  = H_SYNC_DEF,
  parameter int H_BP    = H_BP_DEF,
  parameter int V_VIS   = V_VIS_DEF,
  parameter int V_FP    = V_FP_DEF,
  parameter int V_SYNC  = V_SYNC_DEF,
  parameter int V_BP    = V_BP_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic [7:0]  wr_x,
  input  logic [7:0]  wr_y,
  input  logic [11:0] wr_color,
  output logic        wr_oob,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        frame_start
);

  localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);
  localparam logic [9:0] H_VIS_L  = 10'(H_VIS);
  localparam logic [9:0] H_LAST   = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] HS_BEG   = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [9:0] V_VIS_L  = 10'(V_VIS);
  localparam logic [9:0] V_LAST   = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] VS_BEG   = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_VIS + V_FP + V_SYNC - 1);

  logic [3:0]       div_r;
  logic             tick_s;
  logic [9:0]       hcnt_r;
  logic [9:0]       vcnt_r;
  logic             active_s;
  logic             hs_s;
  logic             vs_s;
  logic             first_s;
  logic [FB_AW-1:0] rd_addr_s;
  logic             wr_ok_s;
  logic             wr_bad_s;
  logic [FB_AW-1:0] wr_addr_s;

  logic             p1_vld_r;
  logic [FB_AW-1:0] rd_addr_r;
  logic             p1_active_r;
  logic             p1_hs_r;
  logic             p1_vs_r;
  logic             p1_first_r;

  logic             out_active_r;
  logic             hs_r;
  logic             vs_r;
  logic             frame_start_r;
  logic             wr_oob_r;
  color_t           rd_data_s;

  assign tick_s = (div_r == DIV_LAST);

  // Write-side range check and address
  always_comb begin
    wr_ok_s   = 1'b0;
    wr_bad_s  = 1'b0;
    wr_addr_s = fb_addr(wr_x, wr_y);
    if (wr_en) begin
      if ((wr_x < FB_W_XY) && (wr_y < FB_H_XY)) begin
        wr_ok_s = 1'b1;
      end else begin
        wr_bad_s = 1'b1;
      end
    end else begin
      wr_ok_s  = 1'b0;
      wr_bad_s = 1'b0;
    end
  end

  // Scan-position decode: visibility, sync windows, frame origin, read address
  always_comb begin
    active_s  = (hcnt_r < H_VIS_L) && (vcnt_r < V_VIS_L);
    hs_s      = !((hcnt_r >= HS_BEG) && (hcnt_r <= HS_END));
    vs_s      = !((vcnt_r >= VS_BEG) && (vcnt_r <= VS_END));
    first_s   = (hcnt_r == 10'd0) && (vcnt_r == 10'd0);
    rd_addr_s = '0;
    if (active_s) begin
      rd_addr_s = fb_addr(hcnt_r[SCALE_SH +: 8], vcnt_r[SCALE_SH +: 8]);
    end else begin
      rd_addr_s = '0;
    end
  end

  // Pixel-rate divider and horizontal/vertical scan counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_r  <= 4'd0;
      hcnt_r <= 10'd0;
      vcnt_r <= 10'd0;
    end else begin
      div_r <= tick_s ? 4'd0 : (div_r + 4'd1);
      if (tick_s) begin
        if (hcnt_r == H_LAST) begin
          hcnt_r <= 10'd0;
          vcnt_r <= (vcnt_r == V_LAST) ? 10'd0 : (vcnt_r + 10'd1);
        end else begin
          hcnt_r <= hcnt_r + 10'd1;
        end
      end
    end
  end

  // Stage 1: capture read address and timing flags of the ticked position
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1_vld_r    <= 1'b0;
      rd_addr_r   <= '0;
      p1_active_r <= 1'b0;
      p1_hs_r     <= 1'b1;
      p1_vs_r     <= 1'b1;
      p1_first_r  <= 1'b0;
    end else begin
      p1_vld_r <= tick_s;
      if (tick_s) begin
        rd_addr_r   <= rd_addr_s;
        p1_active_r <= active_s;
        p1_hs_r     <= hs_s;
        p1_vs_r     <= vs_s;
        p1_first_r  <= first_s;
      end
    end
  end

  // Stage 2: output flags launched together with the RAM read data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_active_r  <= 1'b0;
      hs_r          <= 1'b1;
      vs_r          <= 1'b1;
      frame_start_r <= 1'b0;
    end else begin
      frame_start_r <= p1_vld_r && p1_first_r;
      if (p1_vld_r) begin
        out_active_r <= p1_active_r;
        hs_r         <= p1_hs_r;
        vs_r         <= p1_vs_r;
      end
    end
  end

  // Dropped-write flag, one cycle after the offending strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_oob_r <= 1'b0;
    end else begin
      wr_oob_r <= wr_bad_s;
    end
  end

  fb_ram u_ram (
    .clk   (clk),
    .we    (wr_ok_s),
    .waddr (wr_addr_s),
    .wdata (wr_color),
    .re    (p1_vld_r),
    .raddr (rd_addr_r),
    .rdata (rd_data_s)
  );

  // RAM data is already registered; blanking only masks it with a registered flag
  assign vga_r       = out_active_r ? rd_data_s[11:8] : 4'h0;
  assign vga_g       = out_active_r ? rd_data_s[7:4]  : 4'h0;
  assign vga_b       = out_active_r ? rd_data_s[3:0]  : 4'h0;
  assign vga_hs      = hs_r;
  assign vga_vs      = vs_r;
  assign frame_start = frame_start_r;
  assign wr_oob      = wr_oob_r;

endmodule

// File: tb/tb_fb_vga_scanout.sv
// Directed bench: a full-timing instance (a) checks the top lines of the
// 640x480 raster; a shrunken-timing instance (b) makes whole frames short
// enough to check vertical sync, frame wrap, dropped writes and reset restart.
// Output for tick n (n = v*H_TOTAL + h) is visible after edge 4n+5 and is
// sampled 1 ns after edge 4n+6.
module tb_fb_vga_scanout;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [7:0]  wr_x = 8'd0;
  logic [7:0]  wr_y = 8'd0;
  logic [11:0] wr_color = 12'd0;

  logic a_oob, a_hs, a_vs, a_fs;
  logic [3:0] a_r, a_g, a_b;
  logic b_oob, b_hs, b_vs, b_fs;
  logic [3:0] b_r, b_g, b_b;

  int checks = 0;
  int failures = 0;
  int edge_cnt;

  always #5 clk = ~clk;

  fb_vga_scanout u_dut_a (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y),
    .wr_color(wr_color), .wr_oob(a_oob), .vga_hs(a_hs), .vga_vs(a_vs),
    .vga_r(a_r), .vga_g(a_g), .vga_b(a_b), .frame_start(a_fs)
  );

  // Small raster: 24 ticks/line (hs low h=18..20), 13 lines/frame (vs low v=9..10)
  fb_vga_scanout #(
    .CLK_DIV(4), .H_VIS(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_VIS(8), .V_FP(1), .V_SYNC(2), .V_BP(2)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y),
    .wr_color(wr_color), .wr_oob(b_oob), .vga_hs(b_hs), .vga_vs(b_vs),
    .vga_r(b_r), .vga_g(b_g), .vga_b(b_b), .frame_start(b_fs)
  );

  // Clock edges since the last reset release
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edge_cnt <= 0;
    else        edge_cnt <= edge_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h (edge %0d)", tag, got, exp, edge_cnt);
    end
  endtask

  task automatic wait_edge(input int k);
    while (edge_cnt < k) begin
      @(posedge clk);
      #1;
    end
    check("edge_seq", edge_cnt, k);
  endtask

  task automatic fb_write(input logic [7:0] x, input logic [7:0] y, input logic [11:0] c);
    @(negedge clk);
    wr_en = 1'b1; wr_x = x; wr_y = y; wr_color = c;
  endtask

  function automatic int ea(input int h, input int v);
    return 4 * (v * 800 + h) + 6;
  endfunction

  function automatic int eb(input int f, input int h, input int v);
    return 4 * (f * 312 + v * 24 + h) + 6;
  endfunction

  initial begin
    // Preload during reset: the write path is independent of the scan reset
    fb_write(8'd0,   8'd0,   12'hF00);
    fb_write(8'd1,   8'd0,   12'hABC);
    fb_write(8'd2,   8'd0,   12'h555);
    fb_write(8'd3,   8'd0,   12'h777);
    fb_write(8'd159, 8'd0,   12'h0F0);
    fb_write(8'd0,   8'd1,   12'h123);
    fb_write(8'd159, 8'd119, 12'h0F0);
    @(negedge clk);
    wr_en = 1'b0;
    #1;
    check("rst_a_hs", a_hs, 1'b1);
    check("rst_a_vs", a_vs, 1'b1);
    check("rst_a_rgb", {a_r, a_g, a_b}, 12'h000);
    check("rst_a_oob", a_oob, 1'b0);
    check("rst_a_fs", a_fs, 1'b0);
    check("rst_b_hs", b_hs, 1'b1);
    check("rst_b_vs", b_vs, 1'b1);

    @(negedge clk);
    rst_n = 1'b1;
    wait_edge(4);
    check("pre_tick_rgb", {a_r, a_g, a_b}, 12'h000);
    check("pre_tick_fs", a_fs, 1'b0);
    wait_edge(5);
    check("first_fs_a", a_fs, 1'b1);
    check("first_rgb_a", {a_r, a_g, a_b}, 12'hF00);
    check("first_fs_b", b_fs, 1'b1);
    check("first_rgb_b", {b_r, b_g, b_b}, 12'hF00);
    wait_edge(6);
    check("fs_one_cycle", a_fs, 1'b0);
    check("rgb_hold", {a_r, a_g, a_b}, 12'hF00);

    fork
      begin : full_timing
        wait_edge(ea(3, 0));    check("a_x3y0_red", {a_r, a_g, a_b}, 12'hF00);
        wait_edge(ea(4, 0));    check("a_x4y0", {a_r, a_g, a_b}, 12'hABC);
        wait_edge(ea(639, 0));  check("a_x639_green", {a_r, a_g, a_b}, 12'h0F0);
        wait_edge(ea(640, 0));  check("a_blank640", {a_r, a_g, a_b}, 12'h000);
        wait_edge(ea(655, 0));  check("a_hs655", a_hs, 1'b1);
        wait_edge(ea(656, 0));  check("a_hs656", a_hs, 1'b0);
        check("a_vs_line0", a_vs, 1'b1);
        wait_edge(ea(751, 0));  check("a_hs751", a_hs, 1'b0);
        wait_edge(ea(752, 0));  check("a_hs752", a_hs, 1'b1);
        wait_edge(ea(799, 0));  check("a_blank799", {a_r, a_g, a_b}, 12'h000);
        wait_edge(ea(3, 3));    check("a_x3y3_red", {a_r, a_g, a_b}, 12'hF00);
        wait_edge(ea(636, 3));  check("a_x636y3_green", {a_r, a_g, a_b}, 12'h0F0);
        wait_edge(ea(0, 4));    check("a_x0y4", {a_r, a_g, a_b}, 12'h123);
        check("a_fs_line4", a_fs, 1'b0);
      end
      begin : small_timing
        wait_edge(eb(0, 4, 0));  check("b_h4", {b_r, b_g, b_b}, 12'hABC);
        wait_edge(eb(0, 15, 0)); check("b_h15", {b_r, b_g, b_b}, 12'h777);
        wait_edge(eb(0, 16, 0)); check("b_blank16", {b_r, b_g, b_b}, 12'h000);
        wait_edge(eb(0, 17, 0)); check("b_hs17", b_hs, 1'b1);
        wait_edge(eb(0, 18, 0)); check("b_hs18", b_hs, 1'b0);
        wait_edge(eb(0, 20, 0)); check("b_hs20", b_hs, 1'b0);
        wait_edge(eb(0, 21, 0)); check("b_hs21", b_hs, 1'b1);
        wait_edge(eb(0, 0, 4));  check("b_row1", {b_r, b_g, b_b}, 12'h123);
        wait_edge(eb(0, 0, 8));  check("b_vs8", b_vs, 1'b1);
        check("b_vblank", {b_r, b_g, b_b}, 12'h000);
        wait_edge(eb(0, 0, 9));  check("b_vs9", b_vs, 1'b0);
        wait_edge(eb(0, 23, 10)); check("b_vs10", b_vs, 1'b0);
        wait_edge(eb(0, 0, 11)); check("b_vs11", b_vs, 1'b1);
        // Dropped writes: x=160 would alias pixel (0,1) if not rejected
        wr_en = 1'b1; wr_x = 8'd160; wr_y = 8'd0; wr_color = 12'hFFF;
        @(posedge clk); #1;
        check("oob_x_b", b_oob, 1'b1);
        check("oob_x_a", a_oob, 1'b1);
        wr_x = 8'd0; wr_y = 8'd120;
        @(posedge clk); #1;
        check("oob_y_b", b_oob, 1'b1);
        wr_en = 1'b0; wr_x = 8'd200;
        @(posedge clk); #1;
        check("oob_clear", b_oob, 1'b0);
        wait_edge(eb(0, 23, 12) - 1); check("b_fs_before", b_fs, 1'b0);
        wait_edge(4 * 312 + 5);  check("b_fs_frame1", b_fs, 1'b1);
        check("b_frame1_rgb", {b_r, b_g, b_b}, 12'hF00);
        wait_edge(4 * 312 + 6);  check("b_fs_drop", b_fs, 1'b0);
        // Same-address write while tick (h=8) reads pixel (2,0)
        wait_edge(4 * (312 + 8) + 4);
        wr_en = 1'b1; wr_x = 8'd2; wr_y = 8'd0; wr_color = 12'h00F;
        @(posedge clk); #1;
        wr_en = 1'b0;
        check("b_rw_old", {b_r, b_g, b_b}, 12'h555);
        wait_edge(eb(1, 0, 4)); check("b_oob_unchanged", {b_r, b_g, b_b}, 12'h123);
        wait_edge(eb(2, 8, 0)); check("b_rw_new", {b_r, b_g, b_b}, 12'h00F);
      end
    join

    // Asynchronous reset while the small raster is inside its hsync pulse
    wait_edge(eb(11, 19, 1));
    check("b_hs_before_rst", b_hs, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("async_b_hs", b_hs, 1'b1);
    check("async_b_rgb", {b_r, b_g, b_b}, 12'h000);
    check("async_a_rgb", {a_r, a_g, a_b}, 12'h000);
    check("async_b_fs", b_fs, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_edge(4);
    check("restart_pre_rgb", {b_r, b_g, b_b}, 12'h000);
    check("restart_pre_hs", b_hs, 1'b1);
    wait_edge(5);
    check("restart_fs_b", b_fs, 1'b1);
    check("restart_fs_a", a_fs, 1'b1);
    check("restart_rgb_b", {b_r, b_g, b_b}, 12'hF00);
    wait_edge(eb(0, 4, 0));
    check("kept_b", {b_r, b_g, b_b}, 12'hABC);
    check("kept_a", {a_r, a_g, a_b}, 12'hABC);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
